// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block sequencer: widths, round count,
// default watchdog limit and controller state encoding.
package sha256_pkg;
  localparam int BLK_W       = 512;
  localparam int DIG_W       = 256;
  localparam int RCNT_W      = 7;
  localparam int ROUNDS_DEF  = 64;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK_NEW,
    S_KICK,
    S_RUN,
    S_OUT
  } state_t;
endpackage

// File: rtl/sha256_round_tracker.sv
// Per-block round tracker: STN rising-edge detect, saturating round count and
// the start-to-done watchdog. Cleared at block load, active only while running.
module sha256_round_tracker import sha256_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              stn,
  output logic              stn_rise,
  output logic [RCNT_W-1:0] rounds,
  output logic              timeout
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic              r_stn_q;
  logic [RCNT_W-1:0] r_rounds;
  logic [WD_W-1:0]   r_wd;

  // stn_q tracks the pin every cycle so RUN entry never sees a stale edge
  assign stn_rise = en & stn & ~r_stn_q;
  assign rounds   = r_rounds;
  assign timeout  = en && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stn_q  <= 1'b0;
      r_rounds <= '0;
      r_wd     <= '0;
    end else begin
      r_stn_q <= stn;
      if (clr) begin
        r_rounds <= '0;
        r_wd     <= '0;
      end else if (en) begin
        if (stn_rise && (r_rounds != {RCNT_W{1'b1}})) r_rounds <= r_rounds + 1'b1;
        r_wd <= r_wd + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sha256_block_ctrl.sv
// Host-side sequencer for the SHA-256 compression core and message scheduler:
// accepts tagged blocks, kicks the core, forwards STN and presents the digest.
module sha256_block_ctrl import sha256_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int ROUNDS         = ROUNDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [BLK_W-1:0] blk_data,
  input  logic             blk_first,
  input  logic             blk_last,
  output logic             sched_load,
  output logic [BLK_W-1:0] sched_block,
  output logic             sched_next,
  output logic             comp_start,
  output logic             comp_cont,
  input  logic             comp_stn,
  input  logic             comp_done,
  input  logic [DIG_W-1:0] comp_digest,
  output logic [DIG_W-1:0] digest,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic             busy,
  output logic             err_seq,
  output logic             err_timeout
);
  state_t            r_state;
  logic              r_first, r_last, r_msg_open, r_core_used;
  logic              r_blk_ready, r_sched_load, r_comp_start, r_comp_cont;
  logic              r_digest_valid, r_busy, r_err_seq, r_err_timeout;
  logic [BLK_W-1:0]  r_sched_block;
  logic [DIG_W-1:0]  r_digest;
  logic [RCNT_W-1:0] w_rounds;
  logic              w_timeout;

  sha256_round_tracker #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_trk (
    .clk      (clk),
    .rst      (rst),
    .clr      (r_state == S_LOAD),
    .en       (r_state == S_RUN),
    .stn      (comp_stn),
    .stn_rise (sched_next),
    .rounds   (w_rounds),
    .timeout  (w_timeout)
  );

  assign blk_ready    = r_blk_ready;
  assign sched_load   = r_sched_load;
  assign sched_block  = r_sched_block;
  assign comp_start   = r_comp_start;
  assign comp_cont    = r_comp_cont;
  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;
  assign busy         = r_busy;
  assign err_seq      = r_err_seq;
  assign err_timeout  = r_err_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_first        <= 1'b0;
      r_last         <= 1'b0;
      r_msg_open     <= 1'b0;
      r_core_used    <= 1'b0;
      r_blk_ready    <= 1'b0;
      r_sched_load   <= 1'b0;
      r_comp_start   <= 1'b0;
      r_comp_cont    <= 1'b0;
      r_digest_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_err_seq      <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_sched_block  <= '0;
      r_digest       <= '0;
    end else begin
      r_sched_load <= 1'b0;
      r_comp_start <= 1'b0;
      r_comp_cont  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_blk_ready <= 1'b1;
          r_busy      <= 1'b0;
          if (blk_valid && r_blk_ready) begin
            // a continuation with nothing open is consumed and dropped
            if (!blk_first && !r_msg_open) begin
              r_err_seq <= 1'b1;
            end else begin
              r_sched_block <= blk_data;
              r_first       <= blk_first;
              r_last        <= blk_last;
              r_sched_load  <= 1'b1;
              r_blk_ready   <= 1'b0;
              r_busy        <= 1'b1;
              r_state       <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_comp_start <= 1'b1;
          if (r_first && r_core_used) begin
            r_state <= S_KICK_NEW;
          end else begin
            r_comp_cont <= ~r_first;
            r_state     <= S_KICK;
          end
        end
        S_KICK_NEW: begin
          r_comp_start <= 1'b1;
          r_comp_cont  <= ~r_first;
          r_state      <= S_KICK;
        end
        S_KICK: begin
          r_core_used <= 1'b1;
          r_msg_open  <= 1'b1;
          r_state     <= S_RUN;
        end
        S_RUN: begin
          if (comp_done) begin
            if (w_rounds != RCNT_W'(ROUNDS)) r_err_seq <= 1'b1;
            if (r_last) begin
              r_digest       <= comp_digest;
              r_msg_open     <= 1'b0;
              r_digest_valid <= 1'b1;
              r_state        <= S_OUT;
            end else begin
              r_blk_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_msg_open    <= 1'b0;
            r_core_used   <= 1'b1;
            r_blk_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        S_OUT: begin
          if (digest_ready) begin
            r_digest_valid <= 1'b0;
            r_blk_ready    <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Bench for sha256_block_ctrl: behavioural scheduler+core with real SHA-256 rounds,
// digest scoreboard against known answers, sequencing/watchdog/reset checks.
module tb_sha256_block_ctrl;
  localparam int TB_TO = 200;
  localparam logic [255:0] IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC   = {"abc", 8'h80, 416'h0, 64'h18};
  localparam logic [511:0] B1    = {"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 64'h8000000000000000};
  localparam logic [511:0] B2    = {448'h0, 64'h1c0};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0, rst = 1'b1;
  logic         blk_valid = 1'b0, blk_first = 1'b0, blk_last = 1'b0, digest_ready = 1'b0;
  logic [511:0] blk_data = '0;
  logic         comp_stn = 1'b0, comp_done = 1'b0;
  logic [255:0] comp_digest = '0;
  logic         blk_ready, sched_load, sched_next, comp_start, comp_cont;
  logic         digest_valid, busy, err_seq, err_timeout;
  logic [511:0] sched_block;
  logic [255:0] digest;

  int n_cmp = 0, n_bad = 0;
  int n_next = 0, n_load = 0, n_start = 0, n_run = 0;
  logic cont_seen = 1'b0, core_stub = 1'b0, dv_q = 1'b0, ok;
  logic [255:0] exp_q [$];

  logic [255:0] m_chain = '0, m_base = '0;
  logic [511:0] m_blk = '0;
  logic         m_used = 1'b0, m_run = 1'b0;
  int           m_phase = 0;

  sha256_block_ctrl #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .sched_load(sched_load), .sched_block(sched_block),
    .sched_next(sched_next), .comp_start(comp_start), .comp_cont(comp_cont), .comp_stn(comp_stn),
    .comp_done(comp_done), .comp_digest(comp_digest), .digest(digest), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .busy(busy), .err_seq(err_seq), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, bb, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + bb, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Scheduler + core: 64 one-cycle STN pulses, then a done pulse with the chained hash.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_used <= 1'b0; m_run <= 1'b0; m_chain <= IV;
        comp_stn <= 1'b0; comp_done <= 1'b0; comp_digest <= '0;
      end else begin
        comp_done <= 1'b0;
        if (sched_load) m_blk <= sched_block;
        if (comp_start) begin
          m_base  <= (comp_cont && m_used) ? m_chain : IV;
          m_used  <= 1'b1;
          m_run   <= 1'b1;
          m_phase <= 0;
          comp_stn <= 1'b0;
        end else if (m_run && !core_stub) begin
          m_phase  <= m_phase + 1;
          comp_stn <= (m_phase < 128) && (m_phase % 2 == 0);
          if (m_phase == 129) begin
            m_run       <= 1'b0;
            m_chain     <= sha_compress(m_base, m_blk);
            comp_digest <= sha_compress(m_base, m_blk);
            comp_done   <= 1'b1;
          end
        end
      end
    end
  end

  // Monitor: per-block event counts and the digest scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (sched_next) n_next++;
      if (sched_load) n_load++;
      if (comp_start) begin n_start++; cont_seen = comp_cont; end
      if (busy && !sched_load && !comp_start && !digest_valid) n_run++;
      if (digest_valid && !dv_q) begin
        if (exp_q.size() == 0) chk("extra_digest", 1, 0);
        else chk("digest", digest, exp_q.pop_front());
      end
      dv_q = digest_valid;
    end
  end

  task automatic send(input logic [511:0] d, input logic f, input logic l);
    n_next = 0; n_load = 0; n_start = 0; n_run = 0;
    for (int i = 0; i < 1000 && !blk_ready; i++) @(negedge clk);
    chk("ready_wait", blk_ready, 1);
    blk_data = d; blk_first = f; blk_last = l; blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic wait_dv();
    for (int i = 0; i < 2000 && !digest_valid; i++) @(negedge clk);
    chk("dv_wait", digest_valid, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    chk("idle_wait", busy, 0);
  endtask

  task automatic ack();
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl", {blk_ready, sched_load, sched_next, comp_start, comp_cont, busy,
                    digest_valid, err_seq, err_timeout}, 0);
    chk("rst_digest", digest, 0);
    chk("rst_sblk", |sched_block, 0);
    rst = 1'b0;

    send(ABC, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("seq_err", err_seq, 1);
    chk("seq_noload", n_load, 0);
    chk("seq_nostart", n_start, 0);
    chk("seq_ready", blk_ready, 1);

    exp_q.push_back(ABC_D);
    send(ABC, 1'b1, 1'b1);
    wait_dv();
    chk("abc1_next", n_next, 64);
    chk("abc1_start", n_start, 1);
    chk("abc1_cont", cont_seen, 0);
    ack();

    exp_q.push_back(ABC_D);
    send(ABC, 1'b1, 1'b1);
    wait_dv();
    chk("abc2_start", n_start, 2);
    chk("abc2_cont", cont_seen, 0);
    chk("abc2_next", n_next, 64);
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!digest_valid || digest !== ABC_D || blk_ready) ok = 1'b0;
    end
    chk("hold_stable", ok, 1);
    ack();
    chk("ack_dv", digest_valid, 0);
    chk("ack_ready", blk_ready, 1);
    chk("ack_busy", busy, 0);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_clr_seq", err_seq, 0);

    send(B1, 1'b1, 1'b0);
    wait_idle();
    chk("b1_nodv", digest_valid, 0);
    chk("b1_next", n_next, 64);
    chk("b1_cont", cont_seen, 0);
    exp_q.push_back(TWO_D);
    send(B2, 1'b0, 1'b1);
    wait_dv();
    chk("b2_cont", cont_seen, 1);
    chk("b2_start", n_start, 1);
    ack();
    chk("b2_noseq", err_seq, 0);

    core_stub = 1'b1;
    send(ABC, 1'b1, 1'b1);
    for (int i = 0; i < 1000 && !err_timeout; i++) @(negedge clk);
    chk("to_flag", err_timeout, 1);
    chk("to_cycles", n_run, TB_TO);
    chk("to_idle", {busy, blk_ready}, 2'b01);
    chk("to_nodv", digest_valid, 0);
    core_stub = 1'b0;

    send(ABC, 1'b1, 1'b1);
    for (int i = 0; i < 1000 && n_next < 10; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctl", {blk_ready, sched_load, sched_next, comp_start, comp_cont, busy,
                        digest_valid, err_seq, err_timeout}, 0);
    chk("mid_rst_digest", digest, 0);
    chk("mid_rst_sblk", |sched_block, 0);
    rst = 1'b0;

    exp_q.push_back(ABC_D);
    send(ABC, 1'b1, 1'b1);
    wait_dv();
    ack();
    chk("q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
